// File: rtl/sdpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdpram_pkg
//  Description : Shared constants and elaboration helpers for the asymmetric
//                byte-enabled simple dual-port RAM.
//                - COLL_READ_OLD / COLL_WRITE_THROUGH : collision modes
//                - is_pow2    : power-of-two test for parameter checks
//                - lane_count : byte lanes in a word of a given width
//                - addr_width : word address width for a width and capacity
//  Revision    : 1.0 - initial release
// ============================================================================
package sdpram_pkg;

    localparam int COLL_READ_OLD      = 0;
    localparam int COLL_WRITE_THROUGH = 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_width(input int data_w, input int size_bytes);
        return $clog2((size_bytes * 8) / data_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdpram_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : sdpram_byte_lane
//  Description : One 8-bit RAM column with independent write and registered
//                read. The read register is cleared by reset and otherwise
//                holds its value when no read is requested.
//  Ports       : clk      - clock
//                rst_n    - synchronous active-low reset (read register only)
//                i_we     - write enable for this column
//                i_waddr  - write row
//                i_wdata  - write byte
//                i_re     - read enable
//                i_raddr  - read row
//                o_rdata  - registered read byte (pre-write value on overlap)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdpram_byte_lane #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sdpram_asym_be.sv
`default_nettype none
// ============================================================================
//  Module      : sdpram_asym_be
//  Description : Simple dual-port RAM with independent power-of-two write and
//                read widths, per-byte write enables, 1- or 2-cycle read
//                latency and per-byte same-cycle collision handling.
//                Storage is max(WB,RB) byte columns; byte b lives in column
//                b % columns at row b / columns.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset
//                wr_en    - write strobe
//                wr_addr  - write word address
//                wr_be    - write byte enables, bit i -> wr_data[8i+:8]
//                wr_data  - write data
//                rd_en    - read strobe
//                rd_addr  - read word address
//                rd_valid - rd_data holds the read issued RD_LATENCY ago
//                rd_data  - read data, holds when no new result arrives
//  Revision    : 1.0 - initial release
// ============================================================================
module sdpram_asym_be
    import sdpram_pkg::*;
#(
    parameter int WR_DATA_W      = 32,
    parameter int RD_DATA_W      = 8,
    parameter int SIZE           = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = COLL_READ_OLD
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic [addr_width(WR_DATA_W, SIZE)-1:0] wr_addr,
    input  logic [lane_count(WR_DATA_W)-1:0]       wr_be,
    input  logic [WR_DATA_W-1:0]                   wr_data,
    input  logic                                   rd_en,
    input  logic [addr_width(RD_DATA_W, SIZE)-1:0] rd_addr,
    output logic                                   rd_valid,
    output logic [RD_DATA_W-1:0]                   rd_data
);

    localparam int c_WB       = lane_count(WR_DATA_W);
    localparam int c_RB       = lane_count(RD_DATA_W);
    localparam int c_NL       = (c_WB > c_RB) ? c_WB : c_RB;
    localparam int c_ROW_BITS = c_NL * 8;
    localparam int c_DEPTH    = SIZE / c_NL;
    localparam int c_ROW_W    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_LANE_W   = (c_NL > 1) ? $clog2(c_NL) : 1;
    localparam int c_WR_GRP   = c_NL / c_WB;     // write words per row
    localparam int c_RD_GRP   = c_NL / c_RB;     // read words per row
    localparam int c_WR_SH    = $clog2(c_WR_GRP);
    localparam int c_RD_SH    = $clog2(c_RD_GRP);
    localparam int c_WB_SH    = $clog2(c_WB);
    localparam int c_RB_SH    = $clog2(c_RB);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!is_pow2(WR_DATA_W) || WR_DATA_W < 8) begin : g_bad_wr_w
        $error("sdpram_asym_be: WR_DATA_W must be a power of two >= 8");
    end
    if (!is_pow2(RD_DATA_W) || RD_DATA_W < 8) begin : g_bad_rd_w
        $error("sdpram_asym_be: RD_DATA_W must be a power of two >= 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("sdpram_asym_be: RD_LATENCY must be 1 or 2");
    end
    if (!is_pow2(SIZE) || (SIZE % c_NL) != 0) begin : g_bad_size
        $error("sdpram_asym_be: SIZE must be a power of two multiple of the widest word in bytes");
    end
    if (COLLISION_MODE != COLL_READ_OLD && COLLISION_MODE != COLL_WRITE_THROUGH) begin : g_bad_mode
        $error("sdpram_asym_be: COLLISION_MODE must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Lane steering: a narrow word occupies a contiguous group of columns
    // inside one row; the group's first column is (addr mod words/row)*bytes.
    // ------------------------------------------------------------------
    logic [c_ROW_W-1:0]    w_wr_row;
    logic [c_ROW_W-1:0]    w_rd_row;
    logic [c_LANE_W-1:0]   w_wr_base;
    logic [c_LANE_W-1:0]   w_rd_base;
    logic [c_NL-1:0]       w_lane_we;
    logic [c_ROW_BITS-1:0] w_wd_flat;
    logic [7:0]            w_lane_rdata [c_NL];
    logic [7:0]            w_lane_out   [c_NL];
    logic [c_ROW_BITS-1:0] w_row_flat;
    logic [RD_DATA_W-1:0]  w_rd_data1;

    logic                  r_valid1;
    logic [c_LANE_W-1:0]   r_rd_base;

    assign w_wr_row  = c_ROW_W'(wr_addr >> c_WR_SH);
    assign w_rd_row  = c_ROW_W'(rd_addr >> c_RD_SH);
    assign w_wr_base = c_LANE_W'((32'(wr_addr) & 32'(c_WR_GRP - 1)) << c_WB_SH);
    assign w_rd_base = c_LANE_W'((32'(rd_addr) & 32'(c_RD_GRP - 1)) << c_RB_SH);

    // Writes during reset are dropped here so the columns need no reset gate.
    assign w_lane_we = (c_NL'(wr_be) << w_wr_base) & {c_NL{wr_en & rst_n}};
    assign w_wd_flat = c_ROW_BITS'(wr_data) << {w_wr_base, 3'b000};

    for (genvar l = 0; l < c_NL; l++) begin : g_lane
        sdpram_byte_lane #(
            .DEPTH  (c_DEPTH),
            .ADDR_W (c_ROW_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_lane_we[l]),
            .i_waddr (w_wr_row),
            .i_wdata (w_wd_flat[8*l +: 8]),
            .i_re    (rd_en),
            .i_raddr (w_rd_row),
            .o_rdata (w_lane_rdata[l])
        );
    end

    // Stage-1 bookkeeping only moves on a read so rd_data holds while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid1  <= 1'b0;
            r_rd_base <= '0;
        end else begin
            r_valid1 <= rd_en;
            if (rd_en) begin
                r_rd_base <= w_rd_base;
            end
        end
    end

    // ------------------------------------------------------------------
    // Collision handling. The columns naturally return the pre-write byte;
    // write-through captures, per column, whether this read's row was being
    // written and substitutes the new byte.
    // ------------------------------------------------------------------
    if (COLLISION_MODE == COLL_WRITE_THROUGH) begin : g_wt
        logic [c_NL-1:0] r_wt_hit;
        logic [7:0]      r_wt_byte [c_NL];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wt_hit <= '0;
                for (int l = 0; l < c_NL; l++) begin
                    r_wt_byte[l] <= 8'h00;
                end
            end else if (rd_en) begin
                r_wt_hit <= w_lane_we & {c_NL{w_wr_row == w_rd_row}};
                for (int l = 0; l < c_NL; l++) begin
                    r_wt_byte[l] <= w_wd_flat[8*l +: 8];
                end
            end
        end

        always_comb begin
            for (int l = 0; l < c_NL; l++) begin
                w_lane_out[l] = r_wt_hit[l] ? r_wt_byte[l] : w_lane_rdata[l];
            end
        end
    end else begin : g_read_old
        always_comb begin
            for (int l = 0; l < c_NL; l++) begin
                w_lane_out[l] = w_lane_rdata[l];
            end
        end
    end

    always_comb begin
        w_row_flat = '0;
        for (int l = 0; l < c_NL; l++) begin
            w_row_flat[8*l +: 8] = w_lane_out[l];
        end
    end

    assign w_rd_data1 = RD_DATA_W'(w_row_flat >> {r_rd_base, 3'b000});

    // ------------------------------------------------------------------
    // Output latency
    // ------------------------------------------------------------------
    if (RD_LATENCY == 2) begin : g_lat2
        logic                 r_valid2;
        logic [RD_DATA_W-1:0] r_data2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid2 <= 1'b0;
                r_data2  <= '0;
            end else begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_data2 <= w_rd_data1;
                end
            end
        end

        assign rd_valid = r_valid2;
        assign rd_data  = r_data2;
    end else begin : g_lat1
        assign rd_valid = r_valid1;
        assign rd_data  = w_rd_data1;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdpram_asym_be.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdpram_asym_be
//  Description : Self-checking bench for sdpram_asym_be. Four instances
//                (32->8 L1 read-old, 8->32 L2 write-through, 32->32 L1
//                read-old, 32->32 L1 write-through) share clock and reset and
//                are compared every cycle against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdpram_asym_be;

    localparam int NI = 4;
    localparam int SZ = 64;

    int cfg_wb   [NI] = '{4, 1, 4, 4};
    int cfg_rb   [NI] = '{1, 4, 4, 4};
    int cfg_lat  [NI] = '{1, 2, 1, 1};
    int cfg_mode [NI] = '{0, 1, 0, 1};

    logic clk;
    logic rst_n;

    logic        d_we [NI];
    int          d_wa [NI];
    logic [3:0]  d_be [NI];
    logic [31:0] d_wd [NI];
    logic        d_re [NI];
    int          d_ra [NI];

    logic [3:0]  w0_wa; logic [5:0] w0_ra; logic v0; logic [7:0]  q0;
    logic [5:0]  w1_wa; logic [3:0] w1_ra; logic v1; logic [31:0] q1;
    logic [3:0]  w2_wa; logic [3:0] w2_ra; logic v2; logic [31:0] q2;
    logic [3:0]  w3_wa; logic [3:0] w3_ra; logic v3; logic [31:0] q3;
    logic [0:0]  w1_be;
    logic [7:0]  w1_wd;

    assign w0_wa = 4'(d_wa[0]); assign w0_ra = 6'(d_ra[0]);
    assign w1_wa = 6'(d_wa[1]); assign w1_ra = 4'(d_ra[1]);
    assign w2_wa = 4'(d_wa[2]); assign w2_ra = 4'(d_ra[2]);
    assign w3_wa = 4'(d_wa[3]); assign w3_ra = 4'(d_ra[3]);
    assign w1_be = d_be[1][0:0];
    assign w1_wd = d_wd[1][7:0];

    sdpram_asym_be #(.WR_DATA_W(32), .RD_DATA_W(8), .SIZE(SZ), .RD_LATENCY(1), .COLLISION_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(d_we[0]), .wr_addr(w0_wa), .wr_be(d_be[0]), .wr_data(d_wd[0]),
        .rd_en(d_re[0]), .rd_addr(w0_ra), .rd_valid(v0), .rd_data(q0));
    sdpram_asym_be #(.WR_DATA_W(8), .RD_DATA_W(32), .SIZE(SZ), .RD_LATENCY(2), .COLLISION_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(d_we[1]), .wr_addr(w1_wa), .wr_be(w1_be), .wr_data(w1_wd),
        .rd_en(d_re[1]), .rd_addr(w1_ra), .rd_valid(v1), .rd_data(q1));
    sdpram_asym_be #(.WR_DATA_W(32), .RD_DATA_W(32), .SIZE(SZ), .RD_LATENCY(1), .COLLISION_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(d_we[2]), .wr_addr(w2_wa), .wr_be(d_be[2]), .wr_data(d_wd[2]),
        .rd_en(d_re[2]), .rd_addr(w2_ra), .rd_valid(v2), .rd_data(q2));
    sdpram_asym_be #(.WR_DATA_W(32), .RD_DATA_W(32), .SIZE(SZ), .RD_LATENCY(1), .COLLISION_MODE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(d_we[3]), .wr_addr(w3_wa), .wr_be(d_be[3]), .wr_data(d_wd[3]),
        .rd_en(d_re[3]), .rd_addr(w3_ra), .rd_valid(v3), .rd_data(q3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: flat byte memory plus the result seen after one and
    // two edges of read latency.
    // ------------------------------------------------------------------
    logic [7:0]  mem_m [NI][SZ];
    logic        m_v1 [NI];
    logic        m_v2 [NI];
    logic [31:0] m_d1 [NI];
    logic [31:0] m_d2 [NI];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic get_v(input int k);
        case (k)
            0:       return v0;
            1:       return v1;
            2:       return v2;
            default: return v3;
        endcase
    endfunction

    function automatic logic [31:0] get_q(input int k);
        case (k)
            0:       return {24'h0, q0};
            1:       return q1;
            2:       return q2;
            default: return q3;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s inst%0d got=%h expected=%h", tag, k, got, exp);
    endtask

    task automatic model_edge();
        logic [31:0] rv;
        logic [7:0]  bv;
        int          b;
        int          i;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_v1[k] = 1'b0; m_v2[k] = 1'b0;
                m_d1[k] = '0;   m_d2[k] = '0;
            end else begin
                rv = '0;
                if (d_re[k]) begin
                    for (int j = 0; j < cfg_rb[k]; j++) begin
                        b  = d_ra[k] * cfg_rb[k] + j;
                        bv = mem_m[k][b];
                        if (cfg_mode[k] == 1 && d_we[k]) begin
                            i = b - d_wa[k] * cfg_wb[k];
                            if (i >= 0 && i < cfg_wb[k] && d_be[k][i])
                                bv = d_wd[k][8*i +: 8];
                        end
                        rv[8*j +: 8] = bv;
                    end
                end
                if (m_v1[k]) m_d2[k] = m_d1[k];
                m_v2[k] = m_v1[k];
                m_v1[k] = d_re[k];
                if (d_re[k]) m_d1[k] = rv;
                if (d_we[k]) begin
                    for (int w = 0; w < cfg_wb[k]; w++)
                        if (d_be[k][w]) mem_m[k][d_wa[k] * cfg_wb[k] + w] = d_wd[k][8*w +: 8];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("model_valid", k, 32'(get_v(k)), 32'(cfg_lat[k] == 1 ? m_v1[k] : m_v2[k]));
            chk("model_data",  k, get_q(k),      cfg_lat[k] == 1 ? m_d1[k] : m_d2[k]);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < NI; k++) begin
            d_we[k] = 1'b0; d_wa[k] = 0; d_be[k] = '0; d_wd[k] = '0;
            d_re[k] = 1'b0; d_ra[k] = 0;
        end
    endtask

    task automatic wr(input int k, input int a, input logic [3:0] be, input logic [31:0] d);
        d_we[k] = 1'b1; d_wa[k] = a; d_be[k] = be; d_wd[k] = d;
    endtask

    task automatic rd(input int k, input int a);
        d_re[k] = 1'b1; d_ra[k] = a;
    endtask

    initial begin
        logic [31:0] ds_word;
        int          wwords;
        int          rwords;

        rst_n = 1'b0;
        idle();
        for (int k = 0; k < NI; k++) begin
            m_v1[k] = 1'b0; m_v2[k] = 1'b0; m_d1[k] = '0; m_d2[k] = '0;
            for (int b = 0; b < SZ; b++) mem_m[k][b] = 8'h00;
        end

        // Reset state
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", k, 32'(get_v(k)), 32'd0);
            chk("rst_data",  k, get_q(k),      32'd0);
        end
        rst_n = 1'b1;

        // Preload every byte of every instance
        for (int n = 0; n < SZ; n++) begin
            idle();
            for (int k = 0; k < NI; k++)
                if (n < SZ / cfg_wb[k]) wr(k, n, 4'((1 << cfg_wb[k]) - 1), $urandom);
            step();
        end
        idle();

        // Down-size 32->8: one wide write, four narrow reads back to back
        ds_word = 32'hDDCCBBAA;
        wr(0, 0, 4'hF, ds_word); step(); idle();
        for (int a = 0; a < 4; a++) begin
            rd(0, a); step();
            chk("ds_valid", 0, 32'(get_v(0)), 32'd1);
            chk("ds_data",  0, get_q(0), 32'(ds_word[8*a +: 8]));
        end
        idle();
        repeat (3) begin
            step();
            chk("ds_idle_valid", 0, 32'(get_v(0)), 32'd0);
            chk("ds_idle_hold",  0, get_q(0), 32'hDD);
        end
        rd(0, 1); step(); idle();
        chk("rd_bb", 0, get_q(0), 32'hBB);
        repeat (3) begin
            step();
            chk("bb_idle_valid", 0, 32'(get_v(0)), 32'd0);
            chk("bb_idle_hold",  0, get_q(0), 32'hBB);
        end

        // Up-size 8->32 with two-cycle latency
        for (int a = 0; a < 4; a++) begin
            wr(1, 4 + a, 4'h1, 32'(8'h11 * (a + 1))); step(); idle();
        end
        rd(1, 1); step(); idle();
        chk("us_early_valid", 1, 32'(get_v(1)), 32'd0);
        step();
        chk("us_valid", 1, 32'(get_v(1)), 32'd1);
        chk("us_data",  1, get_q(1), 32'h44332211);
        step();
        chk("us_pulse", 1, 32'(get_v(1)), 32'd0);
        chk("us_hold",  1, get_q(1), 32'h44332211);

        // Byte enables
        wr(2, 2, 4'hF, 32'hFFFFFFFF); step(); idle();
        wr(2, 2, 4'b0101, 32'h12345678); step(); idle();
        rd(2, 2); step(); idle();
        chk("be_data", 2, get_q(2), 32'hFF34FF78);

        // Collisions: read-old (inst2) and write-through (inst3)
        wr(2, 3, 4'hF, 32'hAAAAAAAA); wr(3, 3, 4'hF, 32'hAAAAAAAA); step(); idle();
        wr(2, 3, 4'b0011, 32'h55555555); rd(2, 3);
        wr(3, 3, 4'b0011, 32'h55555555); rd(3, 3);
        step(); idle();
        chk("coll_read_old", 2, get_q(2), 32'hAAAAAAAA);
        chk("coll_wr_thru",  3, get_q(3), 32'hAAAA5555);
        rd(2, 3); rd(3, 3); step(); idle();
        chk("coll_after_m0", 2, get_q(2), 32'hAAAA5555);
        chk("coll_after_m1", 3, get_q(3), 32'hAAAA5555);

        // Reset while a two-cycle read is in flight; write during reset ignored
        rd(1, 1); step(); idle();
        rst_n = 1'b0;
        wr(2, 2, 4'hF, 32'h00000000);
        step(); idle();
        chk("rst_mid_valid", 1, 32'(get_v(1)), 32'd0);
        chk("rst_mid_data",  1, get_q(1), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_after_valid", 1, 32'(get_v(1)), 32'd0);
        chk("rst_after_data",  1, get_q(1), 32'd0);
        rd(1, 1); rd(2, 2); step(); idle();
        chk("rst_keep_be", 2, get_q(2), 32'hFF34FF78);
        step();
        chk("rst_keep_us", 1, get_q(1), 32'h44332211);

        // Randomised traffic with frequent overlaps and occasional reset
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NI; k++) begin
                wwords  = SZ / cfg_wb[k];
                rwords  = SZ / cfg_rb[k];
                d_we[k] = 1'($urandom_range(0, 1));
                d_wa[k] = $urandom_range(0, wwords - 1);
                d_be[k] = 4'($urandom) & 4'((1 << cfg_wb[k]) - 1);
                d_wd[k] = $urandom;
                d_re[k] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1)
                    d_ra[k] = (d_wa[k] * cfg_wb[k]) / cfg_rb[k];
                else
                    d_ra[k] = $urandom_range(0, rwords - 1);
            end
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
